ntt_stage_sequencer: RTL

- Initiator side of the start/burst protocol used by the 64-beat stage counters in the n=512, p=32 NTT datapath.
- On one request it runs NUM_STAGES butterfly stages back to back. For each stage it:
  - issues a one-cycle start pulse;
  - tracks the BURST_LEN-beat burst that the responder counter produces;
  - waits DRAIN_CYCLES for pipeline drain;
  - then advances the stage.
- Raises a one-cycle done pulse when the last stage has drained.

---
 rtl/ntt_stage_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ntt_stage_sequencer.sv
// Initiator side of the NTT stage start/burst protocol: runs NUM_STAGES stages of launch, burst and drain, then pulses done.
// Optional sticky overrun flag for requests arriving mid-transform: define SEQ_OVERRUN_FLAG_EN.
module ntt_stage_sequencer #(
    parameter int NUM_STAGES   = 9,
    parameter int BURST_LEN    = 64,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_start,
    input  logic       in_abort,
    output logic       start_out,
    output logic [3:0] stage_idx,
    output logic [5:0] beat_cnt,
    output logic       beat_valid,
    output logic       busy,
    output logic       done
`ifdef SEQ_OVERRUN_FLAG_EN
    ,
    output logic       overrun
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        BURST,
        DRAIN,
        DONE
    } state_t;

    localparam logic [3:0] STAGE_LAST = 4'(NUM_STAGES - 1);
    localparam logic [5:0] BEAT_LAST  = 6'(BURST_LEN - 1);
    localparam logic [7:0] DRAIN_LAST = 8'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    state_t     state_reg, state_next;
    logic [3:0] stage_reg, stage_next;
    logic [5:0] beat_reg, beat_next;
    logic [7:0] drain_reg, drain_next;
    logic       last_stage;

    assign last_stage = (stage_reg == STAGE_LAST);

    always_comb begin
        state_next = state_reg;
        stage_next = stage_reg;
        beat_next  = beat_reg;
        drain_next = drain_reg;
        if (in_abort) begin
            state_next = IDLE;
            stage_next = 4'd0;
            beat_next  = 6'd0;
            drain_next = 8'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_start) begin
                        state_next = LAUNCH;
                        stage_next = 4'd0;
                        beat_next  = 6'd0;
                    end
                end
                LAUNCH: begin
                    state_next = BURST;
                    beat_next  = 6'd0;
                end
                BURST: begin
                    if (beat_reg == BEAT_LAST) begin
                        beat_next = 6'd0;
                        if (DRAIN_CYCLES > 0) begin
                            state_next = DRAIN;
                            drain_next = 8'd0;
                        end else if (last_stage) begin
                            state_next = DONE;
                        end else begin
                            state_next = LAUNCH;
                            stage_next = stage_reg + 4'd1;
                        end
                    end else begin
                        beat_next = beat_reg + 6'd1;
                    end
                end
                DRAIN: begin
                    if (drain_reg == DRAIN_LAST) begin
                        drain_next = 8'd0;
                        if (last_stage) begin
                            state_next = DONE;
                        end else begin
                            state_next = LAUNCH;
                            stage_next = stage_reg + 4'd1;
                        end
                    end else begin
                        drain_next = drain_reg + 8'd1;
                    end
                end
                DONE: begin
                    state_next = IDLE;
                    stage_next = 4'd0;
                end
                default: begin
                    state_next = IDLE;
                    stage_next = 4'd0;
                    beat_next  = 6'd0;
                    drain_next = 8'd0;
                end
            endcase
        end
    end

    // Pulse/level outputs are registered from the next state so they line up with state_reg.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            stage_reg  <= 4'd0;
            beat_reg   <= 6'd0;
            drain_reg  <= 8'd0;
            start_out  <= 1'b0;
            beat_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef SEQ_OVERRUN_FLAG_EN
            overrun    <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            stage_reg  <= stage_next;
            beat_reg   <= beat_next;
            drain_reg  <= drain_next;
            start_out  <= (state_next == LAUNCH);
            beat_valid <= (state_next == BURST);
            busy       <= (state_next == LAUNCH) || (state_next == BURST) || (state_next == DRAIN);
            done       <= (state_next == DONE);
`ifdef SEQ_OVERRUN_FLAG_EN
            if (state_reg == IDLE && in_start && !in_abort) begin
                overrun <= 1'b0;
            end else if (in_start && state_reg != IDLE && state_reg != DONE) begin
                overrun <= 1'b1;
            end
`endif
        end
    end

    assign stage_idx = stage_reg;
    assign beat_cnt  = beat_reg;

endmodule
